hour_display_scan: RTL
======================

HOUR_DISPLAY_SCAN -- requirements
Module: hour_display_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, giving the clk cycles per digit slot (legal range 1..2^20).
REQ-002 The block SHALL have parameter BLANK_LZ, default 0; when 1, a tens digit of 0 is blanked.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock for all state; all flops are posedge clk.
REQ-004 Port rst, input, 1 bit, SHALL be an asynchronous, active-high reset.
REQ-005 Port ones, input, 4 bits, SHALL carry the hour units digit (0..9) from the hour counter.
REQ-006 Port tens, input, 3 bits, SHALL carry the hour tens digit (0..2) from the hour counter.
REQ-007 Port en, input, 1 bit, SHALL enable the display; when low, digits are dark.
REQ-008 Port seg, output, 7 bits, SHALL drive the active-low segments in the order seg[6:0] = g,f,e,d,c,b,a.
REQ-009 Port an, output, 2 bits, SHALL drive the active-low digit selects: an[0] = units digit, an[1] = tens digit.
REQ-010 Port frame, output, 1 bit, SHALL pulse high for one cycle at the start of each two-slot frame.

Function
REQ-011 Prescaler: the block SHALL count 0..SCAN_DIV-1 and wrap to 0; tick SHALL be asserted in the cycle the count equals SCAN_DIV-1.
REQ-012 If SCAN_DIV = 1, tick SHALL be asserted every cycle.
REQ-013 Slot state: the block SHALL have two states, S_ONES and S_TENS, toggling on every tick: S_ONES->S_TENS and S_TENS->S_ONES.
REQ-014 Snapshot: on a tick taking S_TENS->S_ONES, the block SHALL capture ones and tens into shadow registers; the inputs SHALL be ignored at all other times.
REQ-015 Both digits of one frame SHALL come from the same snapshot, so an input change mid-frame never shows a torn pair.
REQ-016 frame SHALL be asserted in the cycle after the snapshot tick.
REQ-017 seg and an SHALL be registered and SHALL update exactly 1 cycle after the tick that selects the new slot.
REQ-018 In S_ONES, an SHALL be 2'b10; in S_TENS, an SHALL be 2'b01.
REQ-019 Decode (g..a) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 A shadow ones value greater than 9 or a shadow tens value greater than 2 SHALL display a dash, 7'b0111111.
REQ-021 With BLANK_LZ = 1 and shadow tens = 0, seg SHALL be 7'h7F during S_TENS, and an SHALL still follow REQ-018.
REQ-022 With en = 0, seg SHALL be 7'h7F and an SHALL be 2'b11; the prescaler, slot state, snapshot and frame SHALL keep running.
REQ-023 When en rises, the display SHALL resume at the next tick with no restart of the frame.

Reset
REQ-024 While rst is high, the block SHALL hold prescaler = 0, slot = S_TENS, shadows = 0, seg = 7'h7F, an = 2'b11 and frame = 0.
REQ-025 Because slot resets to S_TENS, the first tick after reset release SHALL be a snapshot tick.
REQ-026 Assertion of rst mid-slot SHALL force the REQ-024 values immediately, without waiting for a clk edge.

Verification (SCAN_DIV = 4 unless noted)
REQ-027 Reset, then ones=3, tens=2, en=1 -> the 4th clk after release ticks; frame=1 and seg=0110000, an=2'b10 the next cycle; 4 cycles later seg=0100100, an=2'b01.
REQ-028 Change ones 3->4 during S_TENS -> the tens slot is unchanged; the next units slot shows 0011001.
REQ-029 ones=12 (or tens=5) -> the affected slot shows 7'b0111111.
REQ-030 BLANK_LZ=1, tens=0, ones=7 -> units slot shows 1111000; tens slot shows seg=7'h7F with an=2'b01.
REQ-031 en=0 for 10 cycles -> an=2'b11 and seg=7'h7F throughout, with frame pulses continuing every 8 cycles; after en=1, the next tick shows the correct digit.
REQ-032 SCAN_DIV=1, plus rst pulsed asynchronously mid-cycle -> the slot alternates every cycle before the pulse; outputs go to the REQ-024 values within the same cycle as rst rises.

Source files
------------

// File: rtl/hour_display_scan.sv
// Two-digit multiplexed hour display driver.
// A prescaler divides clk into slot ticks. Each frame scans the units digit and then the tens
// digit. Both digits of a frame come from one snapshot of the hour counter, so a frame never
// shows a mix of old and new digits.
module hour_display_scan #(
  parameter int unsigned SCAN_DIV = 50000,  // clk cycles per digit slot, 1..2^20
  parameter bit          BLANK_LZ = 1'b0    // blank a leading zero in the tens digit
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ones,
  input  logic [2:0] tens,
  input  logic       en,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  // Active-low segment patterns, bit order g,f,e,d,c,b,a.
  localparam logic [6:0] SegDash = 7'b0111111;
  localparam logic [6:0] SegOff  = 7'h7F;
  localparam logic [1:0] AnOnes  = 2'b10;
  localparam logic [1:0] AnTens  = 2'b01;
  localparam logic [1:0] AnOff   = 2'b11;

  typedef enum logic {
    SOnes,
    STens
  } slot_e;

  logic [CntW-1:0] cnt_q, cnt_d;
  slot_e           slot_q, slot_d;
  logic [3:0]      ones_sh_q, ones_sh_d;
  logic [2:0]      tens_sh_q, tens_sh_d;
  logic            frame_q, frame_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;

  logic tick;
  logic snap;

  // 0..9 to active-low segments; anything else shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  // Prescaler and slot sequencing; a snapshot happens on the tick that starts a new frame.
  always_comb begin
    tick   = (cnt_q == CntMax);
    cnt_d  = tick ? '0 : cnt_q + CntW'(1);
    slot_d = slot_q;
    if (tick) begin
      slot_d = (slot_q == STens) ? SOnes : STens;
    end
    snap    = tick && (slot_q == STens);
    frame_d = snap;
  end

  // Shadow registers only load at a frame boundary so both slots show the same pair.
  always_comb begin
    ones_sh_d = ones_sh_q;
    tens_sh_d = tens_sh_q;
    if (snap) begin
      ones_sh_d = ones;
      tens_sh_d = tens;
    end
  end

  // Output next-state: dark while disabled, otherwise reload only on the tick that
  // selects a slot, so re-enabling waits for the next slot boundary.
  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    if (!en) begin
      seg_d = SegOff;
      an_d  = AnOff;
    end else if (tick) begin
      if (slot_d == SOnes) begin
        an_d  = AnOnes;
        seg_d = (ones_sh_d > 4'd9) ? SegDash : seg_decode(ones_sh_d);
      end else begin
        an_d = AnTens;
        if (tens_sh_d > 3'd2) begin
          seg_d = SegDash;
        end else if (BLANK_LZ && (tens_sh_d == 3'd0)) begin
          seg_d = SegOff;
        end else begin
          seg_d = seg_decode({1'b0, tens_sh_d});
        end
      end
    end
  end

  // State registers; slot resets to the tens slot so the first tick takes a snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      slot_q    <= STens;
      ones_sh_q <= '0;
      tens_sh_q <= '0;
      frame_q   <= 1'b0;
      seg_q     <= SegOff;
      an_q      <= AnOff;
    end else begin
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      ones_sh_q <= ones_sh_d;
      tens_sh_q <= tens_sh_d;
      frame_q   <= frame_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
